// File: rtl/flag_handshake_tx_pkg.sv
// Shared types and constants for the source side of the toggle/ack flag crossing.
package flag_handshake_tx_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/flag_handshake_tx_sync_bit.sv
// N-stage single-bit synchroniser, async active-low reset to 0.
module sync_bit
  import flag_handshake_tx_pkg::*;
#(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  // Shorter chains are not metastability-safe, so clamp to the minimum depth.
  localparam int N_EFF = (N < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : N;

  logic [N_EFF-1:0] r_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[N_EFF-2:0], i_d};
    end
  end

  assign o_q = r_chain[N_EFF-1];

endmodule

// File: rtl/flag_handshake_tx.sv
// Source side of a toggle/ack flag crossing: launches one req toggle per event,
// waits for the echoed ack, and queues events that arrive meanwhile.
module flag_handshake_tx
  import flag_handshake_tx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flag_in,
  input  logic                 ack_toggle_async,
  input  logic                 overflow_clr,
  output logic                 req_toggle,
  output logic                 busy,
  output logic                 done_pulse,
  output logic [CNT_WIDTH-1:0] pending,
  output logic                 overflow,
  output logic                 sync_err
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_req;
  logic                 r_done;
  logic [CNT_WIDTH-1:0] r_pending;
  logic                 r_overflow;

  logic                 w_ack_s;
  logic                 w_match;
  logic                 w_avail;
  logic                 w_launch;
  logic                 w_done_next;
  logic                 w_drop;
  logic [CNT_WIDTH-1:0] w_pending_next;
  logic                 w_overflow_next;

  sync_bit #(
    .N (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (ack_toggle_async),
    .o_q   (w_ack_s)
  );

  assign w_match = (w_ack_s == r_req);
  assign w_avail = (r_pending != '0) | flag_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_done     <= 1'b0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_req      <= r_req ^ w_launch;
      r_done     <= w_done_next;
      r_pending  <= w_pending_next;
      r_overflow <= w_overflow_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_avail && w_match) begin
          w_launch     = 1'b1;
          w_state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (w_match) begin
          w_done_next  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // A flag launched in its own cycle never touches the count; a launch without
  // a new flag always has pending != 0 behind it, so no underflow is possible.
  always_comb begin
    w_pending_next = r_pending;
    w_drop         = 1'b0;
    if (flag_in && !w_launch) begin
      if (r_pending == CNT_MAX) begin
        w_drop = 1'b1;
      end else begin
        w_pending_next = r_pending + CNT_WIDTH'(1);
      end
    end else if (!flag_in && w_launch) begin
      w_pending_next = r_pending - CNT_WIDTH'(1);
    end
  end

  assign w_overflow_next = w_drop | (r_overflow & ~overflow_clr);

  assign req_toggle = r_req;
  assign busy       = (r_state == WAIT_ACK);
  assign done_pulse = r_done;
  assign pending    = r_pending;
  assign overflow   = r_overflow;
  assign sync_err   = (r_state == IDLE) && !w_match;

endmodule

// File: tb/tb_flag_handshake_tx.sv
// Directed bench for flag_handshake_tx with a 3-cycle echo model on the ack path.
module tb_flag_handshake_tx;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_WIDTH   = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 flag_in;
  logic                 ack_toggle_async;
  logic                 overflow_clr;
  logic                 req_toggle;
  logic                 busy;
  logic                 done_pulse;
  logic [CNT_WIDTH-1:0] pending;
  logic                 overflow;
  logic                 sync_err;

  logic       echo_rst_n;
  logic       echo_en;
  logic       ack_force;
  logic [2:0] r_echo;

  int checks = 0;
  int errors = 0;

  flag_handshake_tx #(
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flag_in          (flag_in),
    .ack_toggle_async (ack_toggle_async),
    .overflow_clr     (overflow_clr),
    .req_toggle       (req_toggle),
    .busy             (busy),
    .done_pulse       (done_pulse),
    .pending          (pending),
    .overflow         (overflow),
    .sync_err         (sync_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Far-side stand-in: echoes req_toggle back three clk edges later.
  always @(posedge clk or negedge echo_rst_n) begin
    if (!echo_rst_n) r_echo <= 3'b000;
    else             r_echo <= {r_echo[1:0], req_toggle};
  end

  always_comb ack_toggle_async = echo_en ? r_echo[2] : ack_force;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n        = 1'b0;
    echo_rst_n   = 1'b0;
    flag_in      = 1'b0;
    overflow_clr = 1'b0;
    echo_en      = 1'b1;
    ack_force    = 1'b0;
    tick();
    rst_n      = 1'b1;
    echo_rst_n = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},     32'(req_toggle), 32'd0);
    chk({tag, "_busy"},    32'(busy),       32'd0);
    chk({tag, "_done"},    32'(done_pulse), 32'd0);
    chk({tag, "_pending"}, 32'(pending),    32'd0);
    chk({tag, "_ovf"},     32'(overflow),   32'd0);
    chk({tag, "_syncerr"}, 32'(sync_err),   32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    echo_rst_n   = 1'b0;
    flag_in      = 1'b0;
    overflow_clr = 1'b0;
    echo_en      = 1'b1;
    ack_force    = 1'b0;
    #3;
    chk_reset_vals("reset");
    do_reset();

    // Single event: launch at edge 1, done visible after edge 7 only.
    flag_in = 1'b1;
    tick();
    chk("t1_req", 32'(req_toggle), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_pend", 32'(pending), 32'd0);
    flag_in = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk($sformatf("t1_done_k%0d", k), 32'(done_pulse), 32'(k == 7));
      chk($sformatf("t1_busy_k%0d", k), 32'(busy), 32'(k < 7));
    end
    chk("t1_pend_end", 32'(pending), 32'd0);

    // Flag held three cycles: three launches spaced by a round trip each.
    do_reset();
    flag_in = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      chk($sformatf("t2_req_k%0d", k), 32'(req_toggle),
          (k < 8) ? 32'd1 : (k < 15) ? 32'd0 : 32'd1);
      chk($sformatf("t2_pend_k%0d", k), 32'(pending),
          (k == 1) ? 32'd0 : (k == 2) ? 32'd1 : (k < 8) ? 32'd2 : (k < 15) ? 32'd1 : 32'd0);
      chk($sformatf("t2_busy_k%0d", k), 32'(busy),
          32'((k <= 6) || (k >= 8 && k <= 13) || (k >= 15 && k <= 20)));
      chk($sformatf("t2_done_k%0d", k), 32'(done_pulse), 32'(k == 7 || k == 14 || k == 21));
      flag_in = (k < 3);
    end
    chk("t2_ovf", 32'(overflow), 32'd0);

    // No echo: first flag launches, the rest queue until saturation at 15.
    do_reset();
    echo_en   = 1'b0;
    ack_force = 1'b0;
    for (int i = 0; i < 20; i++) begin
      flag_in = 1'b1;
      tick();
      chk($sformatf("t3_pend_i%0d", i), 32'(pending), (i > 15) ? 32'd15 : 32'(i));
      chk($sformatf("t3_ovf_i%0d", i), 32'(overflow), 32'(i >= 16));
      flag_in = 1'b0;
      tick();
    end
    chk("t3_busy", 32'(busy), 32'd1);
    chk("t3_req", 32'(req_toggle), 32'd1);

    // Set wins over clear; clear alone takes effect on the next edge.
    flag_in      = 1'b1;
    overflow_clr = 1'b1;
    tick();
    chk("t4_ovf_setwins", 32'(overflow), 32'd1);
    chk("t4_pend_sat", 32'(pending), 32'd15);
    flag_in = 1'b0;
    tick();
    chk("t4_ovf_cleared", 32'(overflow), 32'd0);
    overflow_clr = 1'b0;

    // Async reset in WAIT_ACK with five events queued.
    do_reset();
    echo_en = 1'b0;
    flag_in = 1'b1;
    repeat (6) tick();
    flag_in = 1'b0;
    chk("t5_pend5", 32'(pending), 32'd5);
    chk("t5_busy_pre", 32'(busy), 32'd1);
    #2;
    rst_n      = 1'b0;
    echo_rst_n = 1'b0;
    #1;
    chk_reset_vals("t5_async");
    tick();
    rst_n      = 1'b1;
    echo_rst_n = 1'b1;
    echo_en    = 1'b1;
    flag_in    = 1'b1;
    tick();
    chk("t5_relaunch_req", 32'(req_toggle), 32'd1);
    chk("t5_relaunch_busy", 32'(busy), 32'd1);
    flag_in = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk($sformatf("t5_done_k%0d", k), 32'(done_pulse), 32'(k == 7));
    end

    // Ack mismatch in IDLE blocks launches and raises sync_err.
    do_reset();
    echo_en   = 1'b0;
    ack_force = 1'b1;
    tick();
    tick();
    chk("t6_syncerr_on", 32'(sync_err), 32'd1);
    flag_in = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("t6_pend_k%0d", k), 32'(pending), 32'(k));
      chk($sformatf("t6_req_k%0d", k), 32'(req_toggle), 32'd0);
      chk($sformatf("t6_busy_k%0d", k), 32'(busy), 32'd0);
    end
    flag_in   = 1'b0;
    ack_force = 1'b0;
    tick();
    chk("t6_syncerr_lag", 32'(sync_err), 32'd1);
    tick();
    chk("t6_syncerr_off", 32'(sync_err), 32'd0);
    chk("t6_req_nolaunch", 32'(req_toggle), 32'd0);
    tick();
    chk("t6_launch_req", 32'(req_toggle), 32'd1);
    chk("t6_launch_busy", 32'(busy), 32'd1);
    chk("t6_launch_pend", 32'(pending), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flag_handshake_tx.md
Name: flag_handshake_tx

Overview:
- Source-side end of a toggle/acknowledge flag crossing.
- Turns event pulses in the local clk domain into level changes on req_toggle and holds off further requests until the far-domain receiver echoes the toggle back on ack_toggle_async.
- Counts events that arrive while a request is outstanding, so multi-cycle or back-to-back flags are never lost or mis-toggled.
- Sits in the local domain, beside the far-domain receiver that recreates pulses from req_toggle and returns its level as the ack.

Parameters:
SYNC_STAGES, 2, flops in the ack synchroniser chain (legal values >= 2).
CNT_WIDTH, 4, width of the pending-event counter (saturates at 2**CNT_WIDTH-1).

Ports:
clk  input  1  local clock; all logic on its rising edge.
rst_n  input  1  asynchronous active-low reset.
flag_in  input  1  event request; every cycle it is high counts as one event.
ack_toggle_async  input  1  toggle level echoed from far domain; asynchronous to clk.
req_toggle  output  1  registered toggle level sent to far domain.
busy  output  1  high while a request is outstanding (state WAIT_ACK).
done_pulse  output  1  one-cycle pulse when the outstanding request is acknowledged.
pending  output  CNT_WIDTH  events accepted but not yet launched.
overflow  output  1  sticky; an event was dropped because pending was saturated.
overflow_clr  input  1  synchronous clear of overflow.
sync_err  output  1  high in IDLE while synchronised ack differs from req_toggle.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, req_toggle 0, sync chain all 0, pending 0, overflow 0, done_pulse 0, busy 0, sync_err 0.
- Ack synchroniser: ack_toggle_async passes through SYNC_STAGES flops; the last stage is ack_s. No other logic touches ack_toggle_async.
- avail = (pending != 0) | flag_in.
- State IDLE:
  - If avail and ack_s == req_toggle: launch. req_toggle inverts at this edge; next state WAIT_ACK.
  - If ack_s != req_toggle: no launch; events keep accumulating in pending; sync_err = 1 (combinational, from registered state).
- State WAIT_ACK:
  - When ack_s == req_toggle: done_pulse = 1 for exactly that cycle (registered, asserted the cycle after the edge where the match is sampled); next state IDLE.
  - Otherwise hold.
  - At least one IDLE cycle always separates two launches.
- busy is the registered state decode; it is high from the cycle after the launch edge until the cycle after the match.
- Latency: flag_in high in cycle N with IDLE and pending = 0 → req_toggle changes after edge N; busy = 1 in cycle N+1.
- Counter: pending_next = pending + flag_in - launch.
  - A flag that is launched in the same cycle it arrives never increments pending.
  - Simultaneous flag_in and launch with pending > 0: pending unchanged.
- Saturation: pending at max, flag_in = 1, no launch → pending stays at max and overflow is set.
- overflow: set has priority over overflow_clr in the same cycle. Otherwise overflow_clr clears it on the next edge.
- Reset mid-operation: everything returns to reset values immediately, including the outstanding request and pending count. The far-domain receiver must be reset together with this block; if it is not, sync_err reports the mismatch and launches are blocked until ack_s equals req_toggle.
- Far-side contract: the receiver drives ack_toggle_async equal to the req_toggle level it has synchronised. Minimum round-trip is SYNC_STAGES plus the receiver's chain, in clk cycles plus far-clock cycles.

Decomposition:
- Shared package: state enum (IDLE, WAIT_ACK) and the SYNC_STAGES minimum constant.
- One sub-module, sync_bit: a parameterised N-stage single-bit synchroniser with async active-low reset to 0, used for ack_toggle_async. The far-domain receiver also reuses it.

Test Plan:
- Single event, bench echoes req_toggle onto ack after 3 clk cycles: flag_in high one cycle at N → req_toggle 0→1 after edge N; busy 1 from N+1; done_pulse for exactly one cycle at N+1+3+SYNC_STAGES (±1 per the echo model); pending stays 0.
- flag_in held high for 3 cycles, echo delay 3: pending goes 0,1,2 after the first launch; three req toggles (0→1→0→1); three done_pulses; pending returns to 0; overflow stays 0.
- Ack never echoed, CNT_WIDTH = 4, 20 single-cycle flags: after the first launch pending saturates at 15; overflow = 1; busy stays 1; req_toggle toggled once.
- overflow_clr asserted in the same cycle as a dropped event → overflow stays 1. overflow_clr asserted alone the next cycle → overflow 0.
- rst_n pulsed low in the middle of WAIT_ACK with pending = 5 → all outputs at reset values immediately. After release, a new flag launches normally once the echo model is also reset.
- Ack forced to 1 while req_toggle = 0 in IDLE → sync_err = 1; flags accumulate in pending with no launch. Ack returned to 0 → sync_err 0 and the launch happens on the next IDLE cycle.
